// File: rtl/icache_assoc_pkg.sv
// Shared types for the set-associative instruction cache.
// Imported by the cache top and its per-way storage.
package icache_assoc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1
  } icache_state_t;

  localparam int WORD_W = 32;

  // Index width that never collapses to zero bits
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set frame storage (tag, valid, block data)
// plus the tag compare for the requested set.
module icache_way
  import icache_assoc_pkg::*;
#(
  parameter int SETS     = 8,
  parameter int BLKWORDS = 2,
  parameter int TW       = 26,
  parameter int IW       = clog2w(SETS),
  parameter int WOW      = clog2w(BLKWORDS)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic [IW-1:0]     rd_idx,
  input  logic [TW-1:0]     rd_tag,
  input  logic [WOW-1:0]    rd_woff,
  output logic              hit,
  output logic              vld,
  output logic [WORD_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [WOW-1:0]    wr_woff,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              inst,
  input  logic [TW-1:0]     inst_tag
);

  typedef struct packed {
    logic [TW-1:0]                    tag;
    logic                             valid;
    logic [BLKWORDS-1:0][WORD_W-1:0]  data;
  } icache_frame_t;

  icache_frame_t frames [SETS];

  assign vld     = frames[rd_idx].valid;
  assign hit     = vld && (frames[rd_idx].tag == rd_tag);
  assign rd_data = frames[rd_idx].data[rd_woff];

  // Only valid bits are cleared; stale data/tags are harmless
  always_ff @(posedge CLK) begin
    if (!nRST || flush) begin
      for (int s = 0; s < SETS; s++)
        frames[s].valid <= 1'b0;
    end else begin
      if (wr_en)
        frames[wr_idx].data[wr_woff] <= wr_data;
      if (inst) begin
        frames[wr_idx].tag   <= inst_tag;
        frames[wr_idx].valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative multi-word-block instruction cache: miss FSM,
// victim selection and per-set round-robin; storage in icache_way.
module icache_assoc
  import icache_assoc_pkg::*;
#(
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int BLKWORDS = 2,
  parameter int CPUID    = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait
);

  localparam int IW  = $clog2(SETS);
  localparam int WO  = $clog2(BLKWORDS);
  localparam int WOW = clog2w(BLKWORDS);
  localparam int RW  = clog2w(WAYS);
  localparam int TW  = 32 - 2 - WO - IW;

  logic [TW-1:0]  rq_tag;
  logic [IW-1:0]  rq_idx;
  logic [WOW-1:0] rq_woff;
  logic           unused_bits;

  assign rq_tag  = imemaddr[31 -: TW];
  assign rq_idx  = imemaddr[WO+2 +: IW];
  assign rq_woff = (BLKWORDS == 1) ? '0 : WOW'(imemaddr[31:2]);
  assign unused_bits = ^{imemaddr[1:0], 1'(CPUID)};

  icache_state_t  state;
  logic [TW-1:0]  miss_tag;
  logic [IW-1:0]  miss_idx;
  logic [WOW-1:0] wcnt;
  logic [RW-1:0]  victim;
  logic [RW-1:0]  vsel;
  logic [RW-1:0]  rr [SETS];

  logic [WAYS-1:0] way_hit;
  logic [WAYS-1:0] way_vld;
  logic [31:0]     way_data [WAYS];

  logic fetching;
  logic last;
  logic wr_en;
  logic inst;
  logic lookup;

  assign fetching = (state == FETCH);
  assign last     = (wcnt == WOW'(BLKWORDS - 1));
  assign wr_en    = fetching && !iwait && !iflush;
  assign inst     = wr_en && last;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .SETS     (SETS),
      .BLKWORDS (BLKWORDS),
      .TW       (TW),
      .IW       (IW),
      .WOW      (WOW)
    ) u_way (
      .CLK      (CLK),
      .nRST     (nRST),
      .flush    (iflush),
      .rd_idx   (rq_idx),
      .rd_tag   (rq_tag),
      .rd_woff  (rq_woff),
      .hit      (way_hit[w]),
      .vld      (way_vld[w]),
      .rd_data  (way_data[w]),
      .wr_en    (wr_en && (victim == RW'(w))),
      .wr_idx   (miss_idx),
      .wr_woff  (wcnt),
      .wr_data  (iload),
      .inst     (inst && (victim == RW'(w))),
      .inst_tag (miss_tag)
    );
  end

  assign lookup = imemREN && (state == IDLE) && (|way_hit);
  assign ihit   = lookup && !iflush;

  always_comb begin
    imemload = '0;
    if (ihit) begin
      for (int w = 0; w < WAYS; w++)
        if (way_hit[w])
          imemload = imemload | way_data[w];
    end
  end

  // Lowest invalid way wins, otherwise the set's round-robin pointer
  always_comb begin
    vsel = rr[rq_idx];
    for (int w = WAYS - 1; w >= 0; w--)
      if (!way_vld[w])
        vsel = RW'(w);
  end

  logic [31:0] base;
  assign base  = {miss_tag, miss_idx, {(WO+2){1'b0}}};
  assign iREN  = fetching;
  assign iaddr = fetching ? (base | (32'(wcnt) << 2)) : '0;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= IDLE;
      wcnt     <= '0;
      victim   <= '0;
      miss_tag <= '0;
      miss_idx <= '0;
      for (int s = 0; s < SETS; s++)
        rr[s] <= '0;
    end else if (iflush) begin
      state <= IDLE;
      wcnt  <= '0;
      for (int s = 0; s < SETS; s++)
        rr[s] <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (imemREN && !lookup) begin
            state    <= FETCH;
            miss_tag <= rq_tag;
            miss_idx <= rq_idx;
            wcnt     <= '0;
            victim   <= vsel;
          end
        end
        (state == FETCH): begin
          if (!iwait) begin
            wcnt <= last ? '0 : WOW'(wcnt + 1'b1);
            if (last) begin
              rr[miss_idx] <= (WAYS == 1) ? '0 : RW'(victim + 1'b1);
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
